// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared state type, default parameters and helpers for mux_rr_arb
package mux_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int N_REQ_DEF    = 5;
   localparam int DW_DEF       = 16;
   localparam int MAX_HOLD_DEF = 8;

   // Grants are at most 16 wide; callers zero-extend narrower one-hot vectors.
   function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority encoder, searching upward from ptr with wrap
module rr_pick
   import mux_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] win,
   output logic             found
);

   // Offset k maps to requester (ptr + k) mod N_REQ; the first requesting offset wins.
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] &&
                ((int'(ptr) + k == i) || (int'(ptr) + k == i + N_REQ))) begin
               win[i] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mux_rr_arb.sv
// rtl/mux_rr_arb.sv - round-robin arbiter steering one requester at a time into a registered output stage
module mux_rr_arb
   import mux_arb_pkg::*;
#(
   parameter  int N_REQ    = N_REQ_DEF,
   parameter  int DW       = DW_DEF,
   parameter  int MAX_HOLD = MAX_HOLD_DEF,
   localparam int IW       = $clog2(N_REQ),
   localparam int CW       = $clog2(MAX_HOLD + 1)
) (
   input  logic                mclk,
   input  logic                mreset_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ-1:0]    last,
   input  logic [N_REQ*DW-1:0] din,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    ack,
   output logic                out_vld,
   output logic [DW-1:0]       out_data,
   output logic [IW-1:0]       out_src,
   input  logic                out_rdy,
   output logic                busy
);

   state_t           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             out_vld_q, out_vld_d;
   logic [DW-1:0]    out_data_q, out_data_d;
   logic [IW-1:0]    out_src_q, out_src_d;

   logic             space, beat, beat_last, g_req, release_g;
   logic [IW-1:0]    g_idx, g_next;
   logic [DW-1:0]    din_g;
   logic [N_REQ-1:0] pick_win;
   logic             pick_found;

   rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .win   (pick_win),
      .found (pick_found)
   );

   assign space     = !out_vld_q || out_rdy;
   assign ack       = gnt_q & req & {N_REQ{space}};
   assign beat      = |ack;
   assign beat_last = |(ack & last);
   assign g_req     = |(gnt_q & req);
   assign g_idx     = IW'(onehot_to_idx(16'(gnt_q)));
   assign g_next    = (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + IW'(1);
   // A withdrawn request releases without taking a beat in that cycle.
   assign release_g = (beat && (beat_last || cnt_q == CW'(MAX_HOLD - 1))) || !g_req;

   always_comb begin
      din_g = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_q[i]) din_g = din_g | din[i*DW +: DW];
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               gnt_d   = pick_win;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (beat) cnt_d = cnt_q + CW'(1);
            if (release_g) begin
               gnt_d   = '0;
               ptr_d   = g_next;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output stage drains whenever it is consumed without a new beat behind it.
   always_comb begin
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
      if (beat) begin
         out_vld_d  = 1'b1;
         out_data_d = din_g;
         out_src_d  = g_idx;
      end else if (out_rdy) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge mclk or negedge mreset_n) begin
      if (!mreset_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         gnt_q      <= '0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_src_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         gnt_q      <= gnt_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         out_src_q  <= out_src_d;
      end
   end

   assign gnt      = gnt_q;
   assign out_vld  = out_vld_q;
   assign out_data = out_data_q;
   assign out_src  = out_src_q;
   assign busy     = (state_q == BUSY);

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb/tb_mux_rr_arb.sv - directed scoreboard bench for mux_rr_arb
module tb_mux_rr_arb;

   localparam int N  = 5;
   localparam int DW = 16;
   localparam int MH = 8;
   localparam int IW = 3;

   logic              mclk     = 1'b0;
   logic              mreset_n = 1'b0;
   logic [N-1:0]      req      = '0;
   logic [N-1:0]      last     = '0;
   logic [N*DW-1:0]   din      = '0;
   logic              out_rdy  = 1'b1;
   logic [N-1:0]      gnt, ack;
   logic              out_vld, busy;
   logic [DW-1:0]     out_data;
   logic [IW-1:0]     out_src;

   int                n_tests = 0;
   int                n_fail  = 0;
   logic              sb_en   = 1'b0;
   logic [IW+DW-1:0]  sb[$];
   logic [IW+DW-1:0]  sb_exp;
   int                ord[6] = '{0, 1, 2, 3, 4, 0};

   always #5 mclk = ~mclk;

   mux_rr_arb #(.N_REQ(N), .DW(DW), .MAX_HOLD(MH)) dut (
      .mclk     (mclk),
      .mreset_n (mreset_n),
      .req      (req),
      .last     (last),
      .din      (din),
      .gnt      (gnt),
      .ack      (ack),
      .out_vld  (out_vld),
      .out_data (out_data),
      .out_src  (out_src),
      .out_rdy  (out_rdy),
      .busy     (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge mclk);
      #1;
   endtask

   task automatic push(input logic [IW-1:0] s, input logic [DW-1:0] d);
      sb.push_back({s, d});
   endtask

   task automatic set_din(input int i, input logic [DW-1:0] v);
      din[i*DW +: DW] = v;
   endtask

   task automatic do_reset();
      mreset_n = 1'b0;
      step();
      mreset_n = 1'b1;
   endtask

   // Output monitor, sampled just ahead of the rising edge that transfers the beat.
   always begin
      @(negedge mclk);
      #4;
      if (mreset_n && sb_en && out_vld && out_rdy) begin
         n_tests++;
         assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL sb_extra: observed beat src %0d data %h expected none", out_src, out_data);
         end
         if (sb.size() > 0) begin
            sb_exp = sb.pop_front();
            chk("sb_src", 32'(out_src), 32'(sb_exp[IW+DW-1:DW]));
            chk("sb_data", 32'(out_data), 32'(sb_exp[DW-1:0]));
         end
      end
   end

   initial begin
      step();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_vld", 32'(out_vld), 32'h0);
      chk("rst_data", 32'(out_data), 32'h0);
      chk("rst_src", 32'(out_src), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      mreset_n = 1'b1;
      sb_en    = 1'b1;

      // single burst from requester 2
      req = 5'b00100;
      set_din(2, 16'hA5A5);
      for (int k = 0; k < 3; k++) push(3'd2, 16'hA5A5);
      step();
      chk("sb1_gnt", 32'(gnt), 32'h04);
      chk("sb1_ack", 32'(ack), 32'h04);
      chk("sb1_busy", 32'(busy), 32'h1);
      step();
      chk("sb1_vld", 32'(out_vld), 32'h1);
      chk("sb1_src", 32'(out_src), 32'h2);
      chk("sb1_data", 32'(out_data), 32'hA5A5);
      step();
      last = 5'b00100;
      step();
      chk("sb1_rel_gnt", 32'(gnt), 32'h0);
      chk("sb1_rel_busy", 32'(busy), 32'h0);
      chk("sb1_last_vld", 32'(out_vld), 32'h1);
      req  = '0;
      last = '0;
      step();
      chk("sb1_drain", 32'(out_vld), 32'h0);

      // pointer now 3: requester 3 beats requester 0
      req  = 5'b01001;
      last = 5'b01001;
      set_din(3, 16'h3333);
      set_din(0, 16'h0BAD);
      push(3'd3, 16'h3333);
      step();
      chk("ptr3_gnt", 32'(gnt), 32'h08);
      step();
      chk("ptr3_rel", 32'(gnt), 32'h0);
      req  = '0;
      last = '0;
      step();
      step();

      // fairness with every requester active
      do_reset();
      req  = 5'b11111;
      last = 5'b11111;
      for (int i = 0; i < N; i++) set_din(i, DW'(16'hF000 + i));
      for (int k = 0; k < 6; k++) begin
         push(IW'(ord[k]), DW'(16'hF000 + ord[k]));
         step();
         chk("fair_gnt", 32'(gnt), 32'd1 << ord[k]);
         step();
         chk("fair_bubble", 32'(gnt), 32'h0);
      end
      req  = '0;
      last = '0;
      step();
      step();

      // hold limit with a lone continuous requester
      req = 5'b00001;
      for (int k = 0; k < MH; k++) begin
         step();
         chk("hold_gnt", 32'(gnt), 32'h01);
         chk("hold_ack", 32'(ack), 32'h01);
         set_din(0, DW'(16'h1000 + k));
         push(3'd0, DW'(16'h1000 + k));
      end
      step();
      chk("hold_bubble", 32'(gnt), 32'h0);
      chk("hold_data", 32'(out_data), 32'h1007);
      chk("hold_src", 32'(out_src), 32'h0);
      step();
      chk("hold_regrant", 32'(gnt), 32'h01);
      req = '0;
      step();
      chk("hold_wd_gnt", 32'(gnt), 32'h0);
      chk("hold_wd_busy", 32'(busy), 32'h0);
      step();

      // backpressure mid-burst on requester 1
      req = 5'b00010;
      step();
      chk("bp_gnt", 32'(gnt), 32'h02);
      set_din(1, 16'h2000);
      push(3'd1, 16'h2000);
      step();
      set_din(1, 16'h2001);
      push(3'd1, 16'h2001);
      step();
      out_rdy = 1'b0;
      set_din(1, 16'h20EE);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("bp_ack", 32'(ack), 32'h0);
         chk("bp_data", 32'(out_data), 32'h2001);
         chk("bp_vld", 32'(out_vld), 32'h1);
         chk("bp_hold", 32'(gnt), 32'h02);
      end
      out_rdy = 1'b1;
      set_din(1, 16'h2002);
      push(3'd1, 16'h2002);
      for (int k = 1; k < 6; k++) begin
         step();
         chk("bp_resume_gnt", 32'(gnt), 32'h02);
         set_din(1, DW'(16'h2002 + k));
         push(3'd1, DW'(16'h2002 + k));
      end
      step();
      chk("bp_release", 32'(gnt), 32'h0);
      req = '0;
      step();
      step();

      // withdrawal of requester 3 with requester 1 waiting
      req = 5'b01010;
      set_din(1, 16'h1111);
      step();
      chk("wd_gnt3", 32'(gnt), 32'h08);
      set_din(3, 16'h3000);
      push(3'd3, 16'h3000);
      step();
      set_din(3, 16'h3001);
      push(3'd3, 16'h3001);
      step();
      chk("wd_gnt3_held", 32'(gnt), 32'h08);
      req = 5'b00010;
      step();
      chk("wd_rel_gnt", 32'(gnt), 32'h0);
      chk("wd_rel_busy", 32'(busy), 32'h0);
      chk("wd_data_kept", 32'(out_data), 32'h3001);
      step();
      chk("wd_gnt1", 32'(gnt), 32'h02);
      req = '0;
      step();
      chk("wd_gnt1_rel", 32'(gnt), 32'h0);
      step();
      step();

      // asynchronous reset mid-burst, between clock edges
      sb_en = 1'b0;
      req   = 5'b00100;
      set_din(2, 16'h7777);
      step();
      chk("ar_gnt", 32'(gnt), 32'h04);
      step();
      chk("ar_vld_before", 32'(out_vld), 32'h1);
      #2;
      mreset_n = 1'b0;
      #1;
      chk("ar_gnt_clr", 32'(gnt), 32'h0);
      chk("ar_vld_clr", 32'(out_vld), 32'h0);
      chk("ar_busy_clr", 32'(busy), 32'h0);
      chk("ar_ack_clr", 32'(ack), 32'h0);
      req = 5'b00110;
      step();
      mreset_n = 1'b1;
      step();
      chk("ar_ptr0_gnt", 32'(gnt), 32'h02);
      req = '0;
      step();
      step();

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_rr_arb.md
Name: mux_rr_arb

Overview:
- Round-robin arbiter and sequencer for a shared N:1 data mux.
- Up to N_REQ requesters each present a request, a data word and a burst-end flag. The block grants one requester at a time and steers its data through the mux into a registered output stage with valid/ready backpressure.
- It replaces fixed-priority select chains in front of shared registers, giving fair access and bounded burst length.

Parameters:
- N_REQ, 5, number of requesters (2..16).
- DW, 16, data width per requester and of the output.
- MAX_HOLD, 8, maximum beats per grant before forced release (1..256).
- Derived localparams: IW = $clog2(N_REQ); CW = $clog2(MAX_HOLD+1).

Ports:
- mclk  input  1  clock; all state is on its rising edge.
- mreset_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester request; must stay high while the requester has data.
- last  input  N_REQ  per-requester burst-end flag; sampled only on an accepted beat.
- din  input  N_REQ*DW  flattened data; requester i occupies din[i*DW +: DW].
- gnt  output  N_REQ  registered one-hot grant; all zero when idle.
- ack  output  N_REQ  combinational per-requester beat-accept strobe.
- out_vld  output  1  output data valid.
- out_data  output  DW  registered muxed data.
- out_src  output  IW  index of the requester that produced out_data.
- out_rdy  input  1  downstream ready.
- busy  output  1  high while in state BUSY.

Behaviour:
- Reset values: gnt=0, out_vld=0, out_data=0, out_src=0, busy=0. Internal state: state=IDLE, ptr=0, cnt=0. ack is 0 whenever gnt=0.
- Output register: loads when (!out_vld || out_rdy), called "space". out_vld holds with out_data stable while out_rdy=0.
- IDLE state:
  - If |req, pick the winner with rotating priority: search from index ptr upward, wrapping modulo N_REQ.
  - Set gnt to the winner's one-hot, clear cnt, go to BUSY.
  - If no req, stay in IDLE with gnt=0.
- BUSY state, granted index g:
  - ack[g] = req[g] & space. All other ack bits are 0.
  - On ack[g]:
    - out_data <= din[g]
    - out_src <= g
    - out_vld <= 1
    - cnt <= cnt+1
  - Release occurs on the first of:
    - (a) ack[g] & last[g];
    - (b) ack[g] & (cnt == MAX_HOLD-1);
    - (c) req[g] = 0 (requester withdrew; no beat taken that cycle).
  - On release: gnt <= 0, ptr <= (g+1) mod N_REQ, go to IDLE.
- Output drain: if BUSY has no ack while out_rdy=1 and out_vld=1, out_vld <= 0 (output register drains).
- Latency:
  - 1 cycle from request to grant.
  - 1 cycle from ack to out_vld.
  - One IDLE bubble cycle between consecutive grants.
  - Peak throughput is MAX_HOLD/(MAX_HOLD+1) beats per cycle.
- Simultaneous events:
  - Release and new requests in the same cycle: arbitration happens in the following IDLE cycle using the updated ptr.
  - A requester that just released has the lowest priority next round.
- Fairness: under continuous requests from all N_REQ requesters, each one is granted once every N_REQ grants.
- Requester rule: deasserting req mid-burst is legal and releases the grant. Data already accepted remains in the output register.
- Backpressure: out_rdy=0 stalls acks. cnt does not advance and the grant is held indefinitely; there is no timeout.
- Reset mid-operation:
  - The asynchronous assert immediately clears gnt, out_vld, busy and state.
  - An in-flight out_data beat is dropped.
  - ptr restarts at 0.
- Illegal: last with req low is ignored. din of non-granted requesters is ignored.
- Parameter rule: MAX_HOLD=1 forces release after every beat.

Decomposition:
- Package mux_arb_pkg:
  - state enum {IDLE, BUSY};
  - default constants N_REQ_DEF=5, DW_DEF=16, MAX_HOLD_DEF=8;
  - function onehot_to_idx.
- Sub-module rr_pick:
  - purely combinational rotating-priority encoder;
  - inputs req[N_REQ] and ptr[IW];
  - outputs a one-hot winner and a found flag.
- The top contains the FSM, counter, pointer and output register.

Test Plan:
- Single burst: reset, req[2]=1 with din2=0xA5A5 for 3 beats, last on beat 3, out_rdy=1 → gnt=5'b00100 at cycle 1; out_vld beats at cycles 2..4 with out_src=2; gnt=0 at cycle 4; ptr=3.
- Fairness: req=5'b11111 held, last on every beat, out_rdy=1 → grant order 0,1,2,3,4,0, with one idle cycle between grants.
- Hold limit: req[0] continuous with no last, MAX_HOLD=8 → exactly 8 acks, then release; next grant to index 0 follows one IDLE cycle later (it is the only requester).
- Backpressure: during a burst, hold out_rdy=0 for 4 cycles → ack=0, out_data stable, cnt frozen; on resume, beats continue with none lost or duplicated.
- Withdrawal: req[3] drops after 2 beats without last → grant released; ptr=4; req[1] waiting is granted next.
- Async reset: assert mreset_n low mid-burst, between clock edges → gnt, out_vld and busy go to 0 immediately; after release, first grant uses ptr=0 (lowest requesting index wins).
